// File: rtl/piso_shifter_if.sv
// Handshake and data bundle between a parallel source / serial sink and piso_shifter.
// The master drives load/enable/data; the slave (the shifter) drives the serial and status outputs.
interface piso_if #(
  parameter int WIDTH = 8
);
  logic             en_n;
  logic             ld;
  logic [WIDTH-1:0] din;
  logic             si;
  logic             so;
  logic             so_n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output en_n, ld, din, si,
    input  so, so_n, busy, done, dout
  );

  modport slave (
    input  en_n, ld, din, si,
    output so, so_n, busy, done, dout
  );
endinterface

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter with load/busy/done handshake, stall and serial capture.
// Define PISO_CONTINUOUS_EN to let a load on the final-shift edge reload for gapless streaming.
module piso_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   ck,
  input  logic   rst_n,
  piso_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  // The outgoing end and the end si enters are fixed by bit order.
  always_comb begin
    if (MSB_FIRST) begin
      out_bit = dat_q[WIDTH-1];
      shifted = {dat_q[WIDTH-2:0], bus.si};
    end else begin
      out_bit = dat_q[0];
      shifted = {bus.si, dat_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          dat_d   = bus.din;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.en_n) begin
          so_d  = out_bit;
          dat_d = shifted;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef PISO_CONTINUOUS_EN
            if (bus.ld) begin
              dat_d   = bus.din;
              cnt_d   = CW'(WIDTH);
              state_d = SHIFT;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign bus.so   = so_q;
  assign bus.so_n = ~so_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.dout = dat_q;

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: one MSB-first and one LSB-first instance, WIDTH=8.
// Expected values are hand-derived constants from the word patterns used.
module tb_piso_shifter;

  logic ck;
  logic rst_n;
  int   checks;
  int   errors;

  piso_if #(.WIDTH(8)) bm ();
  piso_if #(.WIDTH(8)) bl ();

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.ck(ck), .rst_n(rst_n), .bus(bm));
  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.ck(ck), .rst_n(rst_n), .bus(bl));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  // One shift edge on the MSB-first instance, checking so/done/busy.
  task automatic shift_m(input string tag, input logic b, input logic last);
    step();
    chk({tag, "_so"}, 32'(bm.so), 32'(b));
    chk({tag, "_done"}, 32'(bm.done), 32'(last));
    chk({tag, "_busy"}, 32'(bm.busy), 32'(!last));
  endtask

  logic [7:0] pat;
  logic [7:0] pat2;

  initial begin
    checks = 0;
    errors = 0;
    bl.ld = 1'b0; bl.en_n = 1'b1; bl.din = 8'h00; bl.si = 1'b0;

    // Reset with load request asserted: no load may happen
    rst_n = 1'b0; bm.ld = 1'b1; bm.din = 8'hFF; bm.en_n = 1'b0; bm.si = 1'b1;
    step();
    step();
    chk("rst_so", 32'(bm.so), 32'd0);
    chk("rst_so_n", 32'(bm.so_n), 32'd1);
    chk("rst_busy", 32'(bm.busy), 32'd0);
    chk("rst_done", 32'(bm.done), 32'd0);
    chk("rst_dout", 32'(bm.dout), 32'h00);
    chk("rst_dout_l", 32'(bl.dout), 32'h00);
    $display("reset: so=%0b busy=%0b dout=%02h", bm.so, bm.busy, bm.dout);

    // Idle with ld low and en_n low: nothing moves
    rst_n = 1'b1; bm.ld = 1'b0;
    step();
    chk("idle_busy", 32'(bm.busy), 32'd0);
    chk("idle_dout", 32'(bm.dout), 32'h00);

    // Basic MSB-first word, load wins over en_n=0 on the load edge
    pat = 8'hA5;
    bm.ld = 1'b1; bm.din = pat; bm.en_n = 1'b0; bm.si = 1'b1;
    step();
    bm.ld = 1'b0;
    chk("ld_busy", 32'(bm.busy), 32'd1);
    chk("ld_so", 32'(bm.so), 32'd0);
    chk("ld_done", 32'(bm.done), 32'd0);
    chk("ld_dout", 32'(bm.dout), 32'hA5);
    for (int k = 0; k < 8; k++) shift_m("basic", pat[7-k], k == 7);
    chk("basic_dout", 32'(bm.dout), 32'hFF);
    $display("basic: load A5 -> dout=%02h so=%0b", bm.dout, bm.so);
    step();
    chk("post_so_hold", 32'(bm.so), 32'd1);
    chk("post_done", 32'(bm.done), 32'd0);
    chk("post_busy", 32'(bm.busy), 32'd0);

    // Stall for 3 cycles after the 2nd shift
    bm.ld = 1'b1; bm.din = pat;
    step();
    bm.ld = 1'b0;
    for (int k = 0; k < 2; k++) shift_m("stall_a", pat[7-k], 1'b0);
    bm.en_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_so", 32'(bm.so), 32'd0);
      chk("stall_busy", 32'(bm.busy), 32'd1);
      chk("stall_done", 32'(bm.done), 32'd0);
      chk("stall_dout", 32'(bm.dout), 32'h97);
    end
    bm.en_n = 1'b0;
    for (int k = 2; k < 8; k++) shift_m("stall_b", pat[7-k], k == 7);
    chk("stall_final_dout", 32'(bm.dout), 32'hFF);
    $display("stall: word completed 11 edges after load, dout=%02h", bm.dout);

    // LSB-first: load 01, si alternating starting with 1
    bl.ld = 1'b1; bl.din = 8'h01; bl.en_n = 1'b0;
    step();
    bl.ld = 1'b0;
    pat2 = 8'h01;
    for (int k = 0; k < 8; k++) begin
      bl.si = (k % 2 == 0);
      step();
      chk("lsb_so", 32'(bl.so), 32'(pat2[k]));
      chk("lsb_done", 32'(bl.done), 32'(k == 7));
    end
    chk("lsb_busy", 32'(bl.busy), 32'd0);
    chk("lsb_dout", 32'(bl.dout), 32'h55);
    $display("lsb: load 01 -> dout=%02h", bl.dout);

    // Load request mid-word is ignored
    bm.si = 1'b0; bm.ld = 1'b1; bm.din = pat;
    step();
    bm.ld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bm.ld = (k == 4); bm.din = (k == 4) ? 8'hFF : pat;
      shift_m("intf", pat[7-k], k == 7);
    end
    bm.ld = 1'b0;
    chk("intf_dout", 32'(bm.dout), 32'h00);
    $display("interference: ld ignored, dout=%02h", bm.dout);

    // Reset mid-word after 3 shifts
    bm.ld = 1'b1; bm.din = pat;
    step();
    bm.ld = 1'b0;
    for (int k = 0; k < 3; k++) shift_m("mrst", pat[7-k], 1'b0);
    rst_n = 1'b0;
    step();
    chk("mrst_so", 32'(bm.so), 32'd0);
    chk("mrst_so_n", 32'(bm.so_n), 32'd1);
    chk("mrst_busy", 32'(bm.busy), 32'd0);
    chk("mrst_done", 32'(bm.done), 32'd0);
    chk("mrst_dout", 32'(bm.dout), 32'h00);
    rst_n = 1'b1;
    step();
    chk("mrst_idle_busy", 32'(bm.busy), 32'd0);
    $display("mid-word reset: busy=%0b dout=%02h", bm.busy, bm.dout);

    // Load on the final-shift edge
    bm.si = 1'b1; bm.ld = 1'b1; bm.din = pat;
    step();
    bm.ld = 1'b0;
    for (int k = 0; k < 7; k++) shift_m("fin", pat[7-k], 1'b0);
    bm.ld = 1'b1; bm.din = 8'h3C;
    step();
    bm.ld = 1'b0;
    chk("fin_so", 32'(bm.so), 32'd1);
    chk("fin_done", 32'(bm.done), 32'd1);
`ifdef PISO_CONTINUOUS_EN
    chk("cont_busy", 32'(bm.busy), 32'd1);
    chk("cont_dout", 32'(bm.dout), 32'h3C);
    pat2 = 8'h3C;
    for (int k = 0; k < 8; k++) shift_m("cont", pat2[7-k], k == 7);
    $display("continuous: reload 3C streamed without gap");
`else
    chk("noc_busy", 32'(bm.busy), 32'd0);
    chk("noc_dout", 32'(bm.dout), 32'hFF);
    step();
    chk("noc_idle_busy", 32'(bm.busy), 32'd0);
    $display("non-continuous: final-edge ld ignored, dout=%02h", bm.dout);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
# piso_shifter

Parametrised, fully synchronous parallel-in/serial-out shift register: the next-generation replacement for the fixed 8-bit parallel-load shifter in the Nascom hardware simulation. It adds configurable width and bit order, a load/busy/done handshake with a bit counter, a clock-enable stall, and parallel capture of the serial input. It sits between a parallel data source (keyboard matrix, UART/cassette logic, video data) and a serial consumer.

## Interface

- WIDTH, 8, number of bits per word; legal range 2..32.
- MSB_FIRST, 1, 1: shift out din[WIDTH-1] first and take si in at bit 0; 0: shift out din[0] first and take si in at bit WIDTH-1.
- ck  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en_n  in  1  shift enable, active-low; high stalls shifting.
- ld  in  1  load request, active-high; sampled on the rising edge.
- din  in  WIDTH  parallel load data.
- si  in  1  serial input, shifted into the vacated end of the register.
- so  out  1  serial output, registered.
- so_n  out  1  combinational inverse of so.
- busy  out  1  high while a word is being shifted.
- done  out  1  one-cycle pulse: the final bit of the word is on so.
- dout  out  WIDTH  current shift-register contents (captured si bits after a full word).

## Operation

- Internal state: shift register dat[WIDTH-1:0], down-counter cnt of $clog2(WIDTH+1) bits, and a 2-state FSM IDLE/SHIFT. busy = (state == SHIFT). dout = dat.
- Reset, when rst_n=0 at the edge (overrides everything, including mid-word): state=IDLE, cnt=0, dat=0, so=0 (so_n=1), busy=0, done=0.
- IDLE:
  - ld=1: dat<=din, cnt<=WIDTH, go to SHIFT. so is unchanged.
  - ld=0: everything holds. en_n is ignored; there is no free-running shift.
- SHIFT, en_n=0 (shift cycle):
  - so <= outgoing bit (dat[WIDTH-1] if MSB_FIRST, else dat[0]).
  - dat shifts toward the outgoing end, and si enters the opposite end.
  - cnt <= cnt-1.
  - If cnt==1 (final shift): done<=1 and go to IDLE.
- SHIFT, en_n=1: dat, cnt, so and state hold; done<=0.
- done is 0 on every edge except the final shift.
- ld while busy=1 is ignored; the word in flight is never corrupted. The exception is the final-shift case under Configuration.
- Simultaneous ld and en_n=0 in IDLE: the load wins and no shift happens that cycle.
- After WIDTH shifts, dout holds the WIDTH si bits:
  - MSB_FIRST=1: first-received bit is at dout[WIDTH-1].
  - MSB_FIRST=0: first-received bit is at dout[0].

## Timing

- The load edge is not a shift edge.
- Bit k (k=0 first) appears on so after the (k+1)th shift edge.
- With en_n held low, word latency is WIDTH cycles after the load edge.
- done is high during the cycle in which the final bit is on so; busy falls on the same edge.
- Minimum word period without the macro is WIDTH+1 cycles (one IDLE cycle to reload). Every en_n=1 cycle in SHIFT adds one cycle.
- so holds its value between shift edges and after the word completes, until the next shift edge or reset.

## Configuration

- PISO_CONTINUOUS_EN defined: ld=1 on the final-shift edge reloads.
  - Same edge: dat<=din, cnt<=WIDTH, state stays SHIFT, busy stays 1, done still pulses.
  - The next word's first bit follows on the next shift edge, giving gapless streaming with a word period of exactly WIDTH cycles.
- PISO_CONTINUOUS_EN undefined: ld is ignored on the final-shift edge as on any busy cycle, and the block returns to IDLE.

## Test plan

- Reset: rst_n=0 for 2 edges with ld=1, din=0xFF → so=0, so_n=1, busy=0, done=0, dout=0x00; no load occurs.
- WIDTH=8, MSB_FIRST=1: load 0xA5, en_n=0, si=1 → so sequence 1,0,1,0,0,1,0,1 on edges 1..8; done high only after edge 8; busy falls on edge 8; dout=0xFF.
- Stall: same load, en_n=1 for 3 cycles after the 2nd shift → so holds 0, dout and busy hold, done arrives 11 edges after the load; bit sequence unchanged.
- MSB_FIRST=0: load 0x01, si alternating 1,0,… → so = 1,0,0,0,0,0,0,0; dout=0x55.
- Interference: load 0xA5, then ld=1 with din=0xFF after the 4th shift → ignored; so still completes the 0xA5 pattern. rst_n=0 after the 3rd shift → next edge gives all reset values and state IDLE.
- PISO_CONTINUOUS_EN: load 0xA5, ld=1 with din=0x3C on the 8th shift edge → done pulses, busy stays 1, next 8 so bits are 0,0,1,1,1,1,0,0 with no gap cycle.
